// File: rtl/jtsdram_pkg.sv
// jtsdram shared definitions
// channel states and default abort limit
package jtsdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } chan_st_e;

  localparam logic [9:0] TIMEOUT_DEF = 10'd1000;

endpackage

// File: rtl/jtsdram_ba_chan.sv
// jtsdram single-bank request channel
// FSM, address latch, abort counter, read capture
module jtsdram_ba_chan
  import jtsdram_pkg::*;
#(
  parameter int              AW      = 22,
  parameter int              TOW     = 10,
  parameter logic [TOW-1:0]  TIMEOUT = TIMEOUT_DEF,
  parameter bit              WR_EN   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   wr_data,
  input  logic [1:0]    wr_mask,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic          abort,
  output logic          in_req,
  output logic [15:0]   rd_data,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [15:0]   din,
  output logic [1:0]    din_m,
  output logic [AW-1:0] addr,
  input  logic          ack,
  input  logic          rdy,
  input  logic [15:0]   data_read
);

  chan_st_e        st_q, st_d;
  logic [TOW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [15:0]     din_q, din_d;
  logic [1:0]      mask_q, mask_d;
  logic [15:0]     data_q, data_d;
  logic            brd_q, brd_d;
  logic            bwr_q, bwr_d;
  logic            err_q, err_d;
  logic            tmo;
  logic            posted;

  // next state, latches and request strobes
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    data_d  = data_q;
    err_d   = 1'b0;
    abort   = 1'b0;
    tmo     = cnt_q >= TIMEOUT;
    posted  = brd_q | bwr_q;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    unique case (st_q)
      ST_IDLE: begin
        if (req) begin
          st_d   = ST_REQ;
          cnt_d  = '0;
          addr_d = req_addr;
          wr_d   = WR_EN & req_wr;
          din_d  = wr_data;
          mask_d = wr_mask;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          st_d  = ST_DONE;
          err_d = 1'b1;
          abort = 1'b1;
        end else if (ack && posted) begin
          if (rdy) begin
            st_d = ST_DONE;
            if (!wr_q) data_d = data_read;
          end else begin
            st_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (tmo) begin
          st_d  = ST_DONE;
          err_d = 1'b1;
          abort = 1'b1;
        end else if (rdy) begin
          st_d = ST_DONE;
          if (!wr_q) data_d = data_read;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    brd_d = (st_q == ST_REQ) && (st_d == ST_REQ) && !wr_q;
    bwr_d = (st_q == ST_REQ) && (st_d == ST_REQ) && wr_q;
  end

  // channel state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      din_q  <= '0;
      mask_q <= '0;
      data_q <= '0;
      brd_q  <= 1'b0;
      bwr_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      wr_q   <= wr_d;
      din_q  <= din_d;
      mask_q <= mask_d;
      data_q <= data_d;
      brd_q  <= brd_d;
      bwr_q  <= bwr_d;
      err_q  <= err_d;
    end
  end

  assign ready   = st_q == ST_IDLE;
  assign done    = st_q == ST_DONE;
  assign in_req  = st_q == ST_REQ;
  assign err     = err_q;
  assign rd_data = data_q;
  assign ba_rd   = brd_q;
  assign ba_wr   = bwr_q;
  assign din     = din_q;
  assign din_m   = mask_q;
  assign addr    = addr_q;

endmodule

// File: rtl/jtsdram_ba_sched.sv
// jtsdram 4-bank request scheduler
// four channels, refresh gating, sticky timeouts
module jtsdram_ba_sched
  import jtsdram_pkg::*;
#(
  parameter int             AW      = 22,
  parameter int             TOW     = 10,
  parameter logic [TOW-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic          req_wr0,
  input  logic [4*AW-1:0] req_addr,
  input  logic [15:0]   wr_data,
  input  logic [1:0]    wr_mask,
  output logic [3:0]    req_ready,
  output logic [3:0]    done,
  output logic [3:0]    err,
  output logic [63:0]   rd_data,
  output logic [3:0]    timeout,
  input  logic          clr_err,
  output logic [3:0]    ba_rd,
  output logic          ba_wr,
  output logic [15:0]   ba0_din,
  output logic [1:0]    ba0_din_m,
  output logic [AW-1:0] ba0_addr,
  output logic [AW-1:0] ba1_addr,
  output logic [AW-1:0] ba2_addr,
  output logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_ack,
  input  logic [3:0]    ba_rdy,
  input  logic [15:0]   data_read,
  input  logic          refresh_win,
  output logic          refresh_en
);

  logic [3:0]    wr_all;
  logic [15:0]   din_all  [4];
  logic [1:0]    m_all    [4];
  logic [AW-1:0] addr_all [4];
  logic [3:0]    abort;
  logic [3:0]    in_req;
  logic [3:0]    tmo_q, tmo_d;
  logic          ref_q, ref_d;
  logic          unused_wr;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    jtsdram_ba_chan #(
      .AW      (AW),
      .TOW     (TOW),
      .TIMEOUT (TIMEOUT),
      .WR_EN   (i == 0)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req[i]),
      .req_wr    ((i == 0) ? req_wr0 : 1'b0),
      .req_addr  (req_addr[i*AW +: AW]),
      .wr_data   ((i == 0) ? wr_data : 16'h0),
      .wr_mask   ((i == 0) ? wr_mask : 2'b0),
      .ready     (req_ready[i]),
      .done      (done[i]),
      .err       (err[i]),
      .abort     (abort[i]),
      .in_req    (in_req[i]),
      .rd_data   (rd_data[16*i +: 16]),
      .ba_rd     (ba_rd[i]),
      .ba_wr     (wr_all[i]),
      .din       (din_all[i]),
      .din_m     (m_all[i]),
      .addr      (addr_all[i]),
      .ack       (ba_ack[i]),
      .rdy       (ba_rdy[i]),
      .data_read (data_read)
    );
  end

  // write path exists only on bank 0
  assign unused_wr = ^{wr_all[3:1], din_all[1], din_all[2],
                       din_all[3], m_all[1], m_all[2], m_all[3]};

  // sticky timeouts (new abort beats clear) and refresh gate
  always_comb begin
    tmo_d = (tmo_q & ~{4{clr_err}}) | abort;
    ref_d = refresh_win & ~(|in_req);
  end

  // flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
      ref_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      ref_q <= ref_d;
    end
  end

  assign timeout    = tmo_q;
  assign refresh_en = ref_q;
  assign ba_wr      = wr_all[0];
  assign ba0_din    = din_all[0];
  assign ba0_din_m  = m_all[0];
  assign ba0_addr   = addr_all[0];
  assign ba1_addr   = addr_all[1];
  assign ba2_addr   = addr_all[2];
  assign ba3_addr   = addr_all[3];

endmodule

// File: tb/tb_jtsdram_ba_sched.sv
// jtsdram_ba_sched testbench
// vector table plus directed multi-cycle sequences
module tb_jtsdram_ba_sched;

  localparam int AW = 22;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic          req_wr0;
  logic [4*AW-1:0] req_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_mask;
  logic [3:0]    req_ready;
  logic [3:0]    done;
  logic [3:0]    err;
  logic [63:0]   rd_data;
  logic [3:0]    timeout;
  logic          clr_err;
  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]    ba_ack;
  logic [3:0]    ba_rdy;
  logic [15:0]   data_read;
  logic          refresh_win;
  logic          refresh_en;

  int cmps  = 0;
  int fails = 0;

  jtsdram_ba_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_wr0     (req_wr0),
    .req_addr    (req_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .req_ready   (req_ready),
    .done        (done),
    .err         (err),
    .rd_data     (rd_data),
    .timeout     (timeout),
    .clr_err     (clr_err),
    .ba_rd       (ba_rd),
    .ba_wr       (ba_wr),
    .ba0_din     (ba0_din),
    .ba0_din_m   (ba0_din_m),
    .ba0_addr    (ba0_addr),
    .ba1_addr    (ba1_addr),
    .ba2_addr    (ba2_addr),
    .ba3_addr    (ba3_addr),
    .ba_ack      (ba_ack),
    .ba_rdy      (ba_rdy),
    .data_read   (data_read),
    .refresh_win (refresh_win),
    .refresh_en  (refresh_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [3:0]  rdy;
    logic [15:0] dr;
    logic        win;
    logic [3:0]  e_ready;
    logic [3:0]  e_rd;
    logic [3:0]  e_done;
    logic [3:0]  e_err;
    logic        e_ref;
  } vec_t;

  vec_t tv [14];

  function automatic vec_t mk(
    input logic [3:0] rq, input logic [3:0] ak,
    input logic [3:0] ry, input logic [15:0] d,
    input logic w, input logic [3:0] erdy,
    input logic [3:0] erd, input logic [3:0] edn,
    input logic [3:0] eer, input logic eref);
    vec_t v;
    v.req = rq; v.ack = ak; v.rdy = ry; v.dr = d; v.win = w;
    v.e_ready = erdy; v.e_rd = erd; v.e_done = edn;
    v.e_err = eer; v.e_ref = eref;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_addr(input int b, input logic [AW-1:0] a);
    req_addr[b*AW +: AW] = a;
  endtask

  initial begin
    logic       rd0_seen;
    logic [3:0] err_seen;
    int         hi;
    bit         got;
    int         dcnt [4];
    logic [3:0] ak, ry;
    logic [15:0] dv;

    rst_n = 1'b0; req = '0; req_wr0 = 1'b0; req_addr = '0;
    wr_data = '0; wr_mask = '0; clr_err = 1'b0; ba_ack = '0;
    ba_rdy = '0; data_read = '0; refresh_win = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", {60'd0, req_ready}, 64'hF);
    chk("rst ba_rd", {60'd0, ba_rd}, 64'h0);
    chk("rst refresh_en", {63'd0, refresh_en}, 64'h0);
    chk("rst rd_data", rd_data, 64'h0);
    chk("rst done/err/tmo", {52'd0, done, err, timeout}, 64'h0);
    refresh_win = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // bank-1 read with refresh gating, then bank-2 ack+rdy
    tv[0]  = mk(4'h2, 4'h0, 4'h0, 16'h0000, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    tv[1]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 4'hD, 4'h0, 4'h0, 4'h0, 1);
    tv[2]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 4'hD, 4'h2, 4'h0, 4'h0, 0);
    tv[3]  = mk(4'h0, 4'h2, 4'h0, 16'h0000, 1, 4'hD, 4'h2, 4'h0, 4'h0, 0);
    tv[4]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 4'hD, 4'h0, 4'h0, 4'h0, 0);
    tv[5]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 4'hD, 4'h0, 4'h0, 4'h0, 1);
    tv[6]  = mk(4'h0, 4'h0, 4'h2, 16'hBEEF, 1, 4'hD, 4'h0, 4'h0, 4'h0, 1);
    tv[7]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 4'hD, 4'h0, 4'h2, 4'h0, 1);
    tv[8]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    tv[9]  = mk(4'h4, 4'h0, 4'h0, 16'h0000, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    tv[10] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 4'hB, 4'h0, 4'h0, 4'h0, 0);
    tv[11] = mk(4'h0, 4'h4, 4'h4, 16'h7777, 0, 4'hB, 4'h4, 4'h0, 4'h0, 0);
    tv[12] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 4'hB, 4'h0, 4'h4, 4'h0, 0);
    tv[13] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);

    set_addr(1, 22'h00_1234);
    set_addr(2, 22'h15_5555);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("row%0d ready", k), {60'd0, req_ready}, {60'd0, tv[k].e_ready});
      chk($sformatf("row%0d ba_rd", k), {60'd0, ba_rd}, {60'd0, tv[k].e_rd});
      chk($sformatf("row%0d done", k), {60'd0, done}, {60'd0, tv[k].e_done});
      chk($sformatf("row%0d err", k), {60'd0, err}, {60'd0, tv[k].e_err});
      chk($sformatf("row%0d refresh_en", k), {63'd0, refresh_en}, {63'd0, tv[k].e_ref});
      req = tv[k].req; ba_ack = tv[k].ack; ba_rdy = tv[k].rdy;
      data_read = tv[k].dr; refresh_win = tv[k].win;
      @(negedge clk);
    end
    chk("t1 ba1_addr", {42'd0, ba1_addr}, {42'd0, 22'h00_1234});
    chk("t1 rd_data[1]", {48'd0, rd_data[31:16]}, 64'hBEEF);
    chk("t5 ba2_addr", {42'd0, ba2_addr}, {42'd0, 22'h15_5555});
    chk("t5 rd_data[2]", {48'd0, rd_data[47:32]}, 64'h7777);

    // bank-0 write
    rd0_seen = 1'b0;
    set_addr(0, 22'h2A_AAAA);
    req = 4'h1; req_wr0 = 1'b1; wr_data = 16'h5A5A; wr_mask = 2'b01;
    @(negedge clk);
    req = 4'h0; req_wr0 = 1'b0; wr_data = 16'hFFFF; wr_mask = 2'b10;
    chk("t2 din latch", {48'd0, ba0_din}, 64'h5A5A);
    chk("t2 mask latch", {62'd0, ba0_din_m}, 64'h1);
    chk("t2 ba0_addr", {42'd0, ba0_addr}, {42'd0, 22'h2A_AAAA});
    rd0_seen |= ba_rd[0];
    @(negedge clk);
    chk("t2 ba_wr up", {63'd0, ba_wr}, 64'h1);
    rd0_seen |= ba_rd[0];
    @(negedge clk);
    chk("t2 ba_wr hold", {63'd0, ba_wr}, 64'h1);
    rd0_seen |= ba_rd[0];
    ba_ack = 4'h1;
    @(negedge clk);
    ba_ack = 4'h0;
    chk("t2 ba_wr drop", {63'd0, ba_wr}, 64'h0);
    rd0_seen |= ba_rd[0];
    ba_rdy = 4'h1; data_read = 16'h1234;
    @(negedge clk);
    ba_rdy = 4'h0; data_read = 16'h0;
    rd0_seen |= ba_rd[0];
    chk("t2 done", {60'd0, done, err}, 64'h10);
    chk("t2 din at done", {46'd0, ba0_din_m, ba0_din}, {46'd0, 2'b01, 16'h5A5A});
    chk("t2 no read capture", {48'd0, rd_data[15:0]}, 64'h0);
    chk("t2 ba_rd0 never", {63'd0, rd0_seen}, 64'h0);
    @(negedge clk);

    // bank-3 timeout
    set_addr(3, 22'h3F_0F0F);
    req = 4'h8;
    hi = 0; got = 0;
    for (int n = 0; n < 1200 && !got; n++) begin
      @(negedge clk);
      req = 4'h0;
      if (done[3]) begin
        got = 1;
        chk("t3 err with done", {63'd0, err[3]}, 64'h1);
        chk("t3 ba_rd dropped", {63'd0, ba_rd[3]}, 64'h0);
        chk("t3 timeout set", {60'd0, timeout}, 64'h8);
      end else if (ba_rd[3]) begin
        hi++;
      end
    end
    chk("t3 done seen", {63'd0, got}, 64'h1);
    chk("t3 ba_rd cycles", 64'(hi), 64'd1000);
    ba_rdy = 4'h8; data_read = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    ba_rdy = 4'h0; data_read = 16'h0;
    chk("t3 stray rdy done", {60'd0, done}, 64'h0);
    chk("t3 stray rdy ready", {60'd0, req_ready}, 64'hF);
    chk("t3 rd_data kept", {48'd0, rd_data[63:48]}, 64'h0);
    chk("t3 timeout sticky", {60'd0, timeout}, 64'h8);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3 clr_err", {60'd0, timeout}, 64'h0);

    // four banks at once, staggered completion
    set_addr(0, 22'h00_0000);
    set_addr(1, 22'h11_1111);
    set_addr(2, 22'h22_2222);
    set_addr(3, 22'h33_3333);
    req = 4'hF;
    err_seen = '0;
    for (int i = 0; i < 4; i++) dcnt[i] = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      req = 4'h0;
      if (t == 0) chk("t4 all busy", {60'd0, req_ready}, 64'h0);
      if (t == 1) chk("t4 all ba_rd", {60'd0, ba_rd}, 64'hF);
      err_seen |= err;
      ak = '0; ry = '0; dv = '0;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) dcnt[i]++;
        if (t == 2 + i) ak[i] = 1'b1;
        if (t == 5 + 2*i) begin
          ry[i] = 1'b1;
          dv = {4{4'(i + 1)}};
        end
      end
      ba_ack = ak; ba_rdy = ry; data_read = dv;
    end
    ba_ack = '0; ba_rdy = '0; data_read = '0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4 done%0d count", i), 64'(dcnt[i]), 64'd1);
    chk("t4 no err", {60'd0, err_seen}, 64'h0);
    chk("t4 rd_data", rd_data, 64'h4444_3333_2222_1111);
    chk("t4 ba3_addr", {42'd0, ba3_addr}, {42'd0, 22'h33_3333});

    // reset in the middle of a request
    set_addr(1, 22'h0A_BCDE);
    refresh_win = 1'b1;
    req = 4'h2;
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    chk("t6 ba_rd before rst", {60'd0, ba_rd}, 64'h2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6 ba_rd after rst", {60'd0, ba_rd}, 64'h0);
    chk("t6 ready after rst", {60'd0, req_ready}, 64'hF);
    chk("t6 rd_data after rst", rd_data, 64'h0);
    chk("t6 refresh after rst", {63'd0, refresh_en}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
